seven_seg_capture: RTL and testbench
====================================

Name: seven_seg_capture

Overview:
- Receive side of our BCD-to-7-segment path: monitors a multiplexed, scanned 7-segment display bus (segments + digit selects) and recovers the BCD digits being displayed.
- Debounces each digit visit and decodes the segment pattern back to BCD.
- Assembles one full frame of DIGITS digits and presents it on a valid/ready output.
- Used for display loopback self-test and for scraping legacy front panels.

Parameters:
- DIGITS, 4, number of scanned digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (2..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  segment levels, active-high; bit6=a, bit5=b … bit0=g.
- dig_sel  input  DIGITS  digit enables, active-high; legal only when exactly one bit is set.
- frame_bcd  output  4*DIGITS  recovered digits; digit i is in bits [4i+3:4i].
- blank_mask  output  DIGITS  bit i=1: digit i was blank (all segments off).
- err_mask  output  DIGITS  bit i=1: digit i held an undecodable pattern.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts the frame.
- overflow  output  1  one-cycle pulse: a completed frame was dropped.

Behaviour:
- Reset: all outputs 0; all internal registers, stability counter and seen flags cleared. Reset asserted mid-frame discards the partial frame.
- Input stage: seg_in and dig_sel registered once (sample stage); all logic below runs on the registered samples.
- Stability:
  - The counter increments while the current {seg, sel} sample equals the previous sample and sel is one-hot.
  - Any change, or a sel that is zero or multi-hot, resets the counter to 0.
  - Saturates once capture fires. A further capture requires a change first, so each digit visit captures once.
- Capture: when the counter reaches STABLE_CYCLES-1, the decoded value is written into the slot indexed by sel and that slot's seen flag is set. A re-visit before frame completion overwrites the slot (latest wins).
- Decode (exact match):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1110011=9.
  - 0000000: bcd 0, blank bit set.
  - Any other pattern: bcd 4'hF, err bit set.
- Frame completion: when all seen flags are set, in the cycle after the last capture:
  - Slots, blank and err are copied to the output registers.
  - out_valid is set and all seen flags are cleared.
- Handshake:
  - out_valid stays high and outputs stay stable until a cycle with out_valid && out_ready.
  - Completion while out_valid && !out_ready: new frame dropped, outputs unchanged, overflow pulses for 1 cycle.
  - Completion in the same cycle as an accepting out_ready: new frame loaded, out_valid stays 1, no overflow.
  - Accept without completion: out_valid falls next cycle.
- Latency: the first input cycle of a stable digit visit produces a capture STABLE_CYCLES+1 cycles later. out_valid rises 1 cycle after the final capture.
- FSM (output side): EMPTY (out_valid=0) -> FULL on completion. FULL -> EMPTY on accept without completion. FULL -> FULL on accept with completion, or on completion without accept (drop).

Optional Feature:
- Macro: SEVEN_SEG_CAPTURE_DP_EN.
- Defined:
  - Adds input seg_dp (1 bit, decimal point, active-high) and output dp_mask (DIGITS).
  - seg_dp is part of the registered sample and the stability comparison.
  - seg_dp is captured per slot alongside the digit, then copied and held with the frame like blank_mask.
  - Reset value 0.
  - DP state does not affect decode or err.
- Undefined: no seg_dp/dp_mask ports; behaviour otherwise identical.

Test Plan:
- Reset: assert rst_n=0 with random inputs -> all outputs 0; release rst_n and hold inputs idle 20 cycles -> out_valid stays 0.
- Nominal frame: scan digits 0..3 with patterns for 1,2,3,4, each held 8 cycles, out_ready=1 -> frame_bcd=16'h4321, blank_mask=0, err_mask=0, out_valid high 1 cycle.
- Debounce: digit 0 shows 1111001 for 3 cycles then toggles (STABLE_CYCLES=4) -> no capture. Then hold 1111001 for 4 cycles -> slot 0=3.
- Blank/error/illegal select:
  - digit 2=0000000, digit 1=1000001, others valid -> blank_mask=4'b0100, err_mask=4'b0010, frame_bcd[7:4]=F.
  - dig_sel=4'b0011 held 10 cycles -> no capture.
- Backpressure: out_ready=0, complete two frames -> first frame held unchanged, overflow pulses once. Then raise out_ready in the completion cycle of a third frame -> third frame loaded, no overflow.
- Reset mid-frame: capture 3 digits, pulse rst_n low, then complete only digit 3 -> no out_valid until all 4 digits are recaptured.

Source files
------------

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: recovers BCD frames from a scanned 7-segment display bus.
// Optional decimal-point capture (seg_dp/dp_mask) when SEVEN_SEG_CAPTURE_DP_EN is defined.
module seven_seg_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    input  logic                  seg_dp,
    output logic [DIGITS-1:0]     dp_mask,
`endif
    output logic [4*DIGITS-1:0]   frame_bcd,
    output logic [DIGITS-1:0]     blank_mask,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow
);
    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [7:0] CAP = 8'(STABLE_CYCLES - 2);
    localparam logic [7:0] SAT = 8'(STABLE_CYCLES - 1);

`ifdef SEVEN_SEG_CAPTURE_DP_EN
    localparam int SW = 8 + DIGITS;
    logic [SW-1:0] smp_in;
    assign smp_in = {seg_dp, seg_in, dig_sel};
`else
    localparam int SW = 7 + DIGITS;
    logic [SW-1:0] smp_in;
    assign smp_in = {seg_in, dig_sel};
`endif

    logic [SW-1:0]        smp_q, prev_q;
    logic [7:0]           cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  slot_q, slot_d, frame_q, frame_d;
    logic [DIGITS-1:0]    bslot_q, bslot_d, eslot_q, eslot_d, seen_q, seen_d;
    logic [DIGITS-1:0]    blank_q, blank_d, err_q, err_d;
    logic                 ovf_q, ovf_d;
    state_t               state_q, state_d;
    logic [DIGITS-1:0]    sel;
    logic [6:0]           seg;
    logic [3:0]           dec_bcd;
    logic                 dec_blank, dec_err, stable, capture, complete, load;

    assign sel = smp_q[DIGITS-1:0];
    assign seg = smp_q[DIGITS+6:DIGITS];

    always_comb begin
        dec_bcd   = 4'hF;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg)
            7'b1111110: dec_bcd = 4'd0;
            7'b0110000: dec_bcd = 4'd1;
            7'b1101101: dec_bcd = 4'd2;
            7'b1111001: dec_bcd = 4'd3;
            7'b0110011: dec_bcd = 4'd4;
            7'b1011011: dec_bcd = 4'd5;
            7'b1011111: dec_bcd = 4'd6;
            7'b1110000: dec_bcd = 4'd7;
            7'b1111111: dec_bcd = 4'd8;
            7'b1110011: dec_bcd = 4'd9;
            7'b0000000: begin dec_bcd = 4'd0; dec_blank = 1'b1; end
            default:    dec_err = 1'b1;
        endcase
    end

    // Counter saturates at SAT so a visit captures exactly once, on the CAP->SAT step.
    always_comb begin
        stable   = (smp_q == prev_q) && (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
        capture  = stable && (cnt_q == CAP);
        cnt_d    = !stable ? 8'd0 : (cnt_q == SAT ? cnt_q : cnt_q + 8'd1);
        complete = &seen_q;
        load     = complete && (state_q == EMPTY || out_ready);
        slot_d   = slot_q;
        bslot_d  = bslot_q;
        eslot_d  = eslot_q;
        seen_d   = complete ? '0 : seen_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && sel[i]) begin
                slot_d[4*i +: 4] = dec_bcd;
                bslot_d[i]       = dec_blank;
                eslot_d[i]       = dec_err;
                seen_d[i]        = 1'b1;
            end
        end
        state_d = state_q;
        frame_d = frame_q;
        blank_d = blank_q;
        err_d   = err_q;
        ovf_d   = 1'b0;
        if (load) begin
            state_d = FULL;
            frame_d = slot_q;
            blank_d = bslot_q;
            err_d   = eslot_q;
        end else if (complete) begin
            ovf_d = 1'b1;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            bslot_q <= '0;
            eslot_q <= '0;
            seen_q  <= '0;
            frame_q <= '0;
            blank_q <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= EMPTY;
        end else begin
            smp_q   <= smp_in;
            prev_q  <= smp_q;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            bslot_q <= bslot_d;
            eslot_q <= eslot_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            blank_q <= blank_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

`ifdef SEVEN_SEG_CAPTURE_DP_EN
    logic [DIGITS-1:0] dp_slot_q, dp_mask_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_slot_q <= '0;
            dp_mask_q <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++)
                if (capture && sel[i]) dp_slot_q[i] <= smp_q[SW-1];
            if (load) dp_mask_q <= dp_slot_q;
        end
    end
    assign dp_mask = dp_mask_q;
`endif

    assign frame_bcd  = frame_q;
    assign blank_mask = blank_q;
    assign err_mask   = err_q;
    assign out_valid  = (state_q == FULL);
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed checks of capture, debounce, decode, handshake and reset.
module tb_seven_seg_capture;
    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                           P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                           P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                           P9 = 7'b1110011;

    logic        clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] frame_bcd;
    logic [3:0]  blank_mask, err_mask;
    logic        out_valid, overflow;
    int          n_assert = 0, n_fail = 0;

    seven_seg_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
        .frame_bcd(frame_bcd), .blank_mask(blank_mask), .err_mask(err_mask),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic visit(input logic [3:0] s, input logic [6:0] p, input int n);
        dig_sel = s;
        seg_in  = p;
        tick(n);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        seg_in  = '0;
        dig_sel = '0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with random inputs
        seg_in    = 7'($urandom);
        dig_sel   = 4'($urandom);
        out_ready = 1'($urandom);
        tick(3);
        chk("rst_frame", 32'(frame_bcd), 0);
        chk("rst_blank", 32'(blank_mask), 0);
        chk("rst_err", 32'(err_mask), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        seg_in  = '0;
        dig_sel = '0;
        rst_n   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle_valid", 32'(out_valid), 0);
        end

        // Nominal frame
        do_reset();
        out_ready = 1'b1;
        visit(4'b0001, P1, 8);
        visit(4'b0010, P2, 8);
        visit(4'b0100, P3, 8);
        visit(4'b1000, P4, 5);
        chk("nom_valid_pre", 32'(out_valid), 0);
        tick(1);
        chk("nom_valid", 32'(out_valid), 1);
        chk("nom_frame", 32'(frame_bcd), 32'h4321);
        chk("nom_blank", 32'(blank_mask), 0);
        chk("nom_err", 32'(err_mask), 0);
        tick(1);
        chk("nom_valid_drop", 32'(out_valid), 0);
        chk("nom_ovf", 32'(overflow), 0);

        // Debounce on digit 0
        do_reset();
        out_ready = 1'b1;
        visit(4'b0010, P7, 8);
        visit(4'b0100, P8, 8);
        visit(4'b1000, P9, 8);
        visit(4'b0001, P3, 3);
        visit(4'b0001, P5, 1);
        visit(4'b0001, P3, 4);
        chk("deb_no_capture", 32'(out_valid), 0);
        dig_sel = '0;
        tick(2);
        chk("deb_valid", 32'(out_valid), 1);
        chk("deb_frame", 32'(frame_bcd), 32'h9873);

        // Blank, undecodable and multi-hot select
        do_reset();
        out_ready = 1'b1;
        visit(4'b0010, 7'b1000001, 8);
        visit(4'b0100, 7'b0000000, 8);
        visit(4'b1000, P6, 8);
        visit(4'b0011, P1, 10);
        chk("multihot_valid", 32'(out_valid), 0);
        visit(4'b0001, P5, 5);
        chk("be_valid_pre", 32'(out_valid), 0);
        tick(1);
        chk("be_valid", 32'(out_valid), 1);
        chk("be_frame", 32'(frame_bcd), 32'h60F5);
        chk("be_blank", 32'(blank_mask), 32'b0100);
        chk("be_err", 32'(err_mask), 32'b0010);

        // Backpressure: hold, drop, then simultaneous accept and load
        do_reset();
        out_ready = 1'b0;
        visit(4'b0001, P1, 8);
        visit(4'b0010, P2, 8);
        visit(4'b0100, P3, 8);
        visit(4'b1000, P4, 6);
        chk("bp_a_valid", 32'(out_valid), 1);
        chk("bp_a_frame", 32'(frame_bcd), 32'h4321);
        tick(2);
        visit(4'b0001, P5, 8);
        visit(4'b0010, P6, 8);
        visit(4'b0100, P7, 8);
        visit(4'b1000, P8, 5);
        chk("bp_b_ovf_pre", 32'(overflow), 0);
        tick(1);
        chk("bp_b_ovf", 32'(overflow), 1);
        chk("bp_b_valid", 32'(out_valid), 1);
        chk("bp_b_frame_held", 32'(frame_bcd), 32'h4321);
        tick(1);
        chk("bp_b_ovf_post", 32'(overflow), 0);
        visit(4'b0001, P9, 8);
        visit(4'b0010, P0, 8);
        visit(4'b0100, P1, 8);
        visit(4'b1000, P2, 5);
        chk("bp_c_pre_frame", 32'(frame_bcd), 32'h4321);
        out_ready = 1'b1;
        tick(1);
        chk("bp_c_valid", 32'(out_valid), 1);
        chk("bp_c_frame", 32'(frame_bcd), 32'h2109);
        chk("bp_c_ovf", 32'(overflow), 0);
        tick(1);
        chk("bp_c_valid_drop", 32'(out_valid), 0);

        // Reset mid-frame
        do_reset();
        out_ready = 1'b1;
        visit(4'b0001, P1, 8);
        visit(4'b0010, P2, 8);
        visit(4'b0100, P3, 8);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        visit(4'b1000, P4, 8);
        chk("mid_no_valid", 32'(out_valid), 0);
        visit(4'b0001, P5, 8);
        visit(4'b0010, P6, 8);
        visit(4'b0100, P7, 5);
        chk("mid_valid_pre", 32'(out_valid), 0);
        tick(1);
        chk("mid_valid", 32'(out_valid), 1);
        chk("mid_frame", 32'(frame_bcd), 32'h4765);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
